// File: rtl/cc_frame_sequencer.sv
// Frame sequencer around the combinational code calculator: loads opt plus five operands from a
// nibble stream, holds them stable for the calculator, and returns the captured result.
module cc_frame_sequencer #(
    parameter int unsigned CALC_WAIT = 1,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [3:0] in_data,
    output logic       in_ready,
    output logic [2:0] cc_opt,
    output logic [3:0] cc_n0,
    output logic [3:0] cc_n1,
    output logic [3:0] cc_n2,
    output logic [3:0] cc_n3,
    output logic [3:0] cc_n4,
    input  logic [9:0] cc_out,
    output logic [9:0] out_n,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       frame_err
);

    localparam int unsigned IW = (TIMEOUT > 0) ? (($clog2(TIMEOUT + 1) > 0) ? $clog2(TIMEOUT + 1) : 1) : 1;

    typedef enum logic [1:0] {StIdle, StLoad, StCalc, StDone} state_e;

    state_e          r_state;
    logic            r_in_ready;
    logic [2:0]      r_opt;
    logic [3:0]      r_n [0:4];
    logic [9:0]      r_out;
    logic            r_out_valid;
    logic            r_frame_err;
    logic [2:0]      r_idx;
    logic [3:0]      r_wait;
    logic [IW-1:0]   r_idle;
    logic            w_accept;

    assign w_accept = in_valid && r_in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_in_ready  <= 1'b1;
            r_opt       <= 3'd0;
            for (int i = 0; i < 5; i++) begin
                r_n[i] <= 4'd0;
            end
            r_out       <= 10'd0;
            r_out_valid <= 1'b0;
            r_frame_err <= 1'b0;
            r_idx       <= 3'd0;
            r_wait      <= 4'd0;
            r_idle      <= '0;
        end else begin
            r_frame_err <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_opt   <= in_data[2:0];
                        r_idx   <= 3'd0;
                        r_idle  <= '0;
                        r_state <= StLoad;
                    end
                end
                StLoad: begin
                    // An accept always wins over a timeout landing on the same edge.
                    if (w_accept) begin
                        r_n[r_idx] <= in_data;
                        r_idle     <= '0;
                        if (r_idx == 3'd4) begin
                            r_wait     <= 4'd0;
                            r_in_ready <= 1'b0;
                            r_state    <= StCalc;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end else if (TIMEOUT != 0) begin
                        if (r_idle == IW'(TIMEOUT - 1)) begin
                            r_idle      <= '0;
                            r_frame_err <= 1'b1;
                            r_state     <= StIdle;
                        end else begin
                            r_idle <= r_idle + 1'b1;
                        end
                    end
                end
                StCalc: begin
                    if (r_wait == 4'(CALC_WAIT - 1)) begin
                        r_out       <= cc_out;
                        r_out_valid <= 1'b1;
                        r_state     <= StDone;
                    end else begin
                        r_wait <= r_wait + 4'd1;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= StIdle;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign cc_opt    = r_opt;
    assign cc_n0     = r_n[0];
    assign cc_n1     = r_n[1];
    assign cc_n2     = r_n[2];
    assign cc_n3     = r_n[3];
    assign cc_n4     = r_n[4];
    assign out_n     = r_out;
    assign out_valid = r_out_valid;
    assign frame_err = r_frame_err;

endmodule

// File: doc/cc_frame_sequencer.md
Name: cc_frame_sequencer

Overview:
Upstream/downstream wrapper stage for the combinational code calculator (CC).
- Accepts a serial frame over a valid/ready nibble stream: one opt beat, then five operand beats.
- Drives registered, stable opt/in_n0..in_n4 into CC and waits a programmable settle time.
- Captures CC's signed 10-bit result and presents it on a valid/ready output handshake.

Parameters:
CALC_WAIT, 1, cycles to hold operands stable before sampling cc_out (legal 1..15)
TIMEOUT, 16, max idle cycles between beats inside a frame before abort; 0 disables

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
in_valid  input  1  upstream beat valid
in_data  input  4  beat payload; beat 0 = opt in [2:0] ([3] ignored), beats 1..5 = in_n0..in_n4
in_ready  output  1  sequencer can accept a beat
cc_opt  output  3  registered opt to CC
cc_n0..cc_n4  output  4 each  registered operands to CC
cc_out  input  10  signed result from CC (combinational)
out_n  output  10  signed captured result
out_valid  output  1  out_n valid
out_ready  input  1  downstream accepts out_n
frame_err  output  1  one-cycle pulse on timeout abort

Behaviour:
- Reset (async assert, sync release): state=IDLE; in_ready=1; cc_opt=0; cc_n0..4=0; out_n=0; out_valid=0; frame_err=0; beat counter, wait counter and idle counter=0.
- Beat accepted when in_valid && in_ready at a rising edge.
- States:
  - IDLE: in_ready=1. On accept, cc_opt<=in_data[2:0] and go to LOAD with idx=0.
  - LOAD: in_ready=1. On accept, cc_n[idx]<=in_data and idx++. Accepting idx=4 goes to CALC with wait=0.
  - CALC: in_ready=0. wait++ each cycle. When wait==CALC_WAIT-1, out_n<=cc_out, out_valid<=1, and go to DONE.
  - DONE: in_ready=0, out_valid=1, out_n held stable. On out_valid && out_ready: out_valid<=0 and go to IDLE. No same-cycle acceptance of the next opt beat.
- Latency: from the last operand accept to out_valid high is exactly CALC_WAIT+1 edges. With CALC_WAIT=1, out_valid is high 2 edges after the 5th operand.
- cc_opt/cc_n* change only on accepted beats. They keep their value from the previous frame until overwritten, so CC inputs are stable during CALC/DONE.
- Timeout (TIMEOUT>0):
  - In LOAD, the idle counter increments on each cycle without an accept and clears on an accept.
  - When it reaches TIMEOUT: go to IDLE, frame_err=1 for one cycle, idle counter=0.
  - Partially loaded cc_n* are not cleared.
  - The idle counter is inactive in IDLE/CALC/DONE.
- Timeout coinciding with an accept: the accept wins and the counter clears.
- out_ready while out_valid=0 is ignored. in_valid during CALC/DONE is not accepted; upstream must hold the beat.
- rst_n low mid-frame or mid-DONE: immediate return to reset values. The pending result is lost.
- Width rules: out_n is captured verbatim as signed two's complement (range -512..511); no saturation or rescaling.

Test Plan:
- Basic eq_2: beats opt=000, then 1,2,3,4,5 back-to-back, CALC_WAIT=1, CC instance attached -> cc_n*=1,2,3,4,5; out_valid 2 edges after last beat; out_n=6 (0x006).
- eq_1 path: opt=100, operands 1,2,3,4,5 -> out_n=7. Hold out_ready=0 for 10 cycles -> out_valid and out_n stay stable and in_ready=0. Pulse out_ready -> out_valid falls, in_ready=1 next cycle.
- Gapped input: opt=000, then operands with 3 idle cycles between each (TIMEOUT=16) -> no frame_err; out_n=6.
- Timeout: opt beat plus 2 operands, then 16 cycles with no in_valid -> frame_err single pulse at the 16th idle edge and state returns to IDLE. A fresh full frame 1..5 with opt=000 -> out_n=6.
- Async reset mid-CALC: assert rst_n low between the last beat and capture -> out_valid=0, out_n=0, cc_*=0 immediately, without waiting for a clock. After release, in_ready=1 and a new frame completes normally.
- Back-to-back frames: drive two frames with in_valid held high continuously -> the second opt beat is not accepted until the cycle after the out handshake; both results are correct and in order.
